// File: rtl/issue_age_queue.sv
// issue_age_queue: reservation-station entry buffer that offers the oldest ready
// entry over a valid/ready handshake, with tag wakeup and a same-cycle bypass.
module issue_age_queue #(
    parameter int DEPTH   = 8,
    parameter int AGE_LEN = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       ins_valid_i,
    output logic                       ins_ready_o,
    input  logic                       ins_rdy_i,
    input  logic [TAG_W-1:0]           ins_tag_i,
    input  logic [DATA_W-1:0]          ins_data_i,
    input  logic                       wake_valid_i,
    input  logic [TAG_W-1:0]           wake_tag_i,
    output logic                       iss_valid_o,
    input  logic                       iss_ready_i,
    output logic [DATA_W-1:0]          iss_data_o,
    output logic [$clog2(DEPTH)-1:0]   iss_idx_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0]   valid_q, valid_d, rdy_q, rdy_d;
    logic [TAG_W-1:0]   tag_q [DEPTH];
    logic [TAG_W-1:0]   tag_d [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  data_d [DEPTH];
    logic [AGE_LEN-1:0] age_q [DEPTH];
    logic [AGE_LEN-1:0] age_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      free_idx, sel_idx;
    logic [AGE_LEN-1:0] best_age;
    logic               ins_fire, iss_fire;

    assign ins_ready_o = count_q != FULL;
    assign count_o     = count_q;
    assign ins_fire    = ins_valid_i & ins_ready_o & ~flush_i;
    assign iss_fire    = iss_valid_o & iss_ready_i;
    assign iss_idx_o   = sel_idx;
    assign iss_data_o  = iss_valid_o ? data_q[sel_idx] : '0;

    // Scanning downward leaves the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = IW'(i);
    end

    // The >= lets a later index win on equal age.
    always_comb begin
        iss_valid_o = 1'b0;
        sel_idx     = '0;
        best_age    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rdy_q[i] && (!iss_valid_o || age_q[i] >= best_age)) begin
                iss_valid_o = 1'b1;
                sel_idx     = IW'(i);
                best_age    = age_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        rdy_d   = rdy_q;
        tag_d   = tag_q;
        data_d  = data_q;
        age_d   = age_q;
        count_d = flush_i ? '0 : count_q + CW'(ins_fire) - CW'(iss_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_i) begin
                valid_d[i] = 1'b0;
                rdy_d[i]   = 1'b0;
                age_d[i]   = '0;
            end else if (ins_fire && free_idx == IW'(i)) begin
                valid_d[i] = 1'b1;
                rdy_d[i]   = ins_rdy_i | (wake_valid_i && wake_tag_i == ins_tag_i);
                tag_d[i]   = ins_tag_i;
                data_d[i]  = ins_data_i;
                age_d[i]   = '0;
            end else if (iss_fire && sel_idx == IW'(i)) begin
                valid_d[i] = 1'b0;
                rdy_d[i]   = 1'b0;
            end else if (valid_q[i]) begin
                age_d[i] = &age_q[i] ? age_q[i] : age_q[i] + 1'b1;
                if (wake_valid_i && tag_q[i] == wake_tag_i) rdy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            rdy_q   <= '0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
            age_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            age_q   <= age_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_issue_age_queue.sv
// tb_issue_age_queue: table-driven vectors plus hand sequences; issued payloads
// are checked against a queue of expected values on every handshake.
module tb_issue_age_queue;
    localparam logic O = 1'b1;
    localparam logic Z = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_n_i, flush_i, ins_valid_i, ins_ready_o, ins_rdy_i;
    logic [2:0]  ins_tag_i, wake_tag_i, iss_idx_o;
    logic [31:0] ins_data_i, iss_data_o;
    logic        wake_valid_i, iss_valid_o, iss_ready_i;
    logic [3:0]  count_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic fl, iv, ir;
        logic [2:0] it;
        logic [31:0] id;
        logic wv;
        logic [2:0] wt;
        logic rr;
        logic e_ir, e_iv;
        logic [2:0] e_idx;
        logic [31:0] e_data;
        logic [3:0] e_cnt;
    } vec_t;
    vec_t vecs [13];

    issue_age_queue dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_rdy_i(ins_rdy_i),
        .ins_tag_i(ins_tag_i), .ins_data_i(ins_data_i),
        .wake_valid_i(wake_valid_i), .wake_tag_i(wake_tag_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_data_o(iss_data_o), .iss_idx_o(iss_idx_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic eir, input logic eiv,
                           input logic [2:0] eidx, input logic [31:0] edata, input logic [3:0] ecnt);
        chk({nm, ".ins_ready"}, 32'(ins_ready_o), 32'(eir));
        chk({nm, ".iss_valid"}, 32'(iss_valid_o), 32'(eiv));
        chk({nm, ".iss_idx"}, 32'(iss_idx_o), 32'(eidx));
        chk({nm, ".iss_data"}, iss_data_o, edata);
        chk({nm, ".count"}, 32'(count_o), 32'(ecnt));
    endtask

    // Called at a negedge: apply inputs, score any handshake, advance one cycle.
    task automatic drive(input logic fl, input logic iv, input logic ir, input logic [2:0] it,
                         input logic [31:0] id, input logic wv, input logic [2:0] wt, input logic rr);
        flush_i = fl; ins_valid_i = iv; ins_rdy_i = ir; ins_tag_i = it; ins_data_i = id;
        wake_valid_i = wv; wake_tag_i = wt; iss_ready_i = rr;
        if (iss_valid_o && iss_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %0h expected no issue", iss_data_o);
            end else chk("issue_data", iss_data_o, exp_q.pop_front());
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rr);
        drive(Z, Z, Z, 3'd0, 32'd0, Z, 3'd0, rr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0; flush_i = 0; ins_valid_i = 0; ins_rdy_i = 0; ins_tag_i = 0;
        ins_data_i = 0; wake_valid_i = 0; wake_tag_i = 0; iss_ready_i = 0;
        vecs[0]  = '{Z, O, O, 3'd0, 32'hA0A0, Z, 3'd0, Z, O, Z, 3'd0, 32'h0,    4'd0};
        vecs[1]  = '{Z, O, O, 3'd0, 32'hB0B0, Z, 3'd0, Z, O, O, 3'd0, 32'hA0A0, 4'd1};
        vecs[2]  = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, Z, O, O, 3'd0, 32'hA0A0, 4'd2};
        vecs[3]  = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, Z, O, O, 3'd0, 32'hA0A0, 4'd2};
        vecs[4]  = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, O, O, O, 3'd0, 32'hA0A0, 4'd2};
        vecs[5]  = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, O, O, O, 3'd1, 32'hB0B0, 4'd1};
        vecs[6]  = '{Z, O, Z, 3'd5, 32'hC0C0, Z, 3'd0, Z, O, Z, 3'd0, 32'h0,    4'd0};
        vecs[7]  = '{Z, Z, Z, 3'd0, 32'h0,    O, 3'd3, Z, O, Z, 3'd0, 32'h0,    4'd1};
        vecs[8]  = '{Z, Z, Z, 3'd0, 32'h0,    O, 3'd5, Z, O, Z, 3'd0, 32'h0,    4'd1};
        vecs[9]  = '{Z, O, Z, 3'd2, 32'hD0D0, O, 3'd2, Z, O, O, 3'd0, 32'hC0C0, 4'd1};
        vecs[10] = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, O, O, O, 3'd0, 32'hC0C0, 4'd2};
        vecs[11] = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, O, O, O, 3'd1, 32'hD0D0, 4'd1};
        vecs[12] = '{Z, Z, Z, 3'd0, 32'h0,    Z, 3'd0, Z, O, Z, 3'd0, 32'h0,    4'd0};

        repeat (2) @(negedge clk_i);
        chk_out("reset", O, Z, 3'd0, 32'd0, 4'd0);
        rst_n_i = 1'b1;

        // Age order, wakeup, wakeup bypass.
        for (int i = 0; i < 13; i++) begin
            chk_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_iv, vecs[i].e_idx,
                    vecs[i].e_data, vecs[i].e_cnt);
            if (vecs[i].rr && vecs[i].e_iv) exp_q.push_back(vecs[i].e_data);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ir, vecs[i].it, vecs[i].id,
                  vecs[i].wv, vecs[i].wt, vecs[i].rr);
        end

        // Full boundary.
        for (int k = 0; k < 8; k++) drive(Z, O, O, 3'd0, 32'(100 + k), Z, 3'd0, Z);
        chk_out("full", Z, O, 3'd0, 32'd100, 4'd8);
        drive(Z, O, O, 3'd0, 32'hDEAD, Z, 3'd0, Z);
        chk_out("full_ignored", Z, O, 3'd0, 32'd100, 4'd8);
        exp_q.push_back(32'd100);
        idle(O);
        chk_out("one_free", O, O, 3'd1, 32'd101, 4'd7);
        for (int k = 1; k < 8; k++) exp_q.push_back(32'(100 + k));
        for (int n = 0; n < 20 && iss_valid_o; n++) idle(O);
        chk_out("drained", O, Z, 3'd0, 32'd0, 4'd0);
        chk("sb_empty_full", 32'(exp_q.size()), 32'd0);

        // Saturated ages tie; highest index wins.
        for (int k = 0; k < 7; k++)
            drive(Z, O, (k == 2 || k == 6) ? O : Z, 3'd1, 32'(200 + k), Z, 3'd0, Z);
        repeat (20) idle(Z);
        chk_out("sat_tie", O, O, 3'd6, 32'd206, 4'd7);
        exp_q.push_back(32'd206);
        idle(O);
        chk_out("sat_next", O, O, 3'd2, 32'd202, 4'd6);
        exp_q.push_back(32'd202);
        idle(O);
        drive(Z, Z, Z, 3'd0, 32'd0, O, 3'd1, Z);
        chk_out("woken", O, O, 3'd5, 32'd205, 4'd5);

        // Flush with concurrent insert and issue handshake.
        exp_q.push_back(32'd205);
        drive(O, O, O, 3'd0, 32'hBAD, Z, 3'd0, O);
        chk_out("flush", O, Z, 3'd0, 32'd0, 4'd0);
        idle(Z);
        chk_out("flush_drop", O, Z, 3'd0, 32'd0, 4'd0);
        chk("sb_empty_flush", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with three live entries.
        for (int k = 0; k < 3; k++) drive(Z, O, O, 3'd0, 32'(300 + k), Z, 3'd0, Z);
        ins_valid_i = Z;
        chk_out("pre_rst", O, O, 3'd0, 32'd300, 4'd3);
        #2 rst_n_i = 1'b0;
        #1 chk_out("async_rst", O, Z, 3'd0, 32'd0, 4'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            chk_out($sformatf("post_rst%0d", n), O, Z, 3'd0, 32'd0, 4'd0);
            idle(O);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
